// File: rtl/crossing_phase_scheduler_pkg.sv
// Shared phase encodings, direction type and default durations for the crossing scheduler.
package traffic_pkg;

    typedef enum logic [2:0] {
        PhGreenH  = 3'd0,
        PhYellowH = 3'd1,
        PhAllredH = 3'd2,
        PhGreenV  = 3'd3,
        PhYellowV = 3'd4,
        PhAllredV = 3'd5,
        PhPreempt = 3'd6
    } phase_e;

    typedef enum logic {DirH = 1'b0, DirV = 1'b1} dir_e;

    localparam logic [2:0] PREEMPT_NONE = 3'b111;

    localparam logic [4:0] DefMinGreen  = 5'd5;
    localparam logic [4:0] DefMaxGreen  = 5'd20;
    localparam logic [4:0] DefYellow    = 5'd3;
    localparam logic [4:0] DefAllred    = 5'd1;
    localparam logic [4:0] DefWalk      = 5'd4;

endpackage

// File: rtl/crossing_phase_scheduler_if.sv
// Demand inputs and phase/walk/countdown outputs of the crossing scheduler.
interface crossing_phase_scheduler_if;
    logic       tick;
    logic       car_wait_hor;
    logic       car_wait_ver;
    logic       ped_req_hor;
    logic       ped_req_ver;
    logic [2:0] preempt_code;
    logic [2:0] phase;
    logic       walk_hor;
    logic       walk_ver;
    logic [1:0] ped_pending;
    logic [4:0] remaining;
    logic       preempt_active;

    modport master (
        output tick, car_wait_hor, car_wait_ver, ped_req_hor, ped_req_ver, preempt_code,
        input  phase, walk_hor, walk_ver, ped_pending, remaining, preempt_active
    );

    modport slave (
        input  tick, car_wait_hor, car_wait_ver, ped_req_hor, ped_req_ver, preempt_code,
        output phase, walk_hor, walk_ver, ped_pending, remaining, preempt_active
    );
endinterface

// File: rtl/crossing_phase_scheduler_phase_timer.sv
// Per-phase elapsed tick counter with a done compare against the loaded exit duration.
module phase_timer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       tick_i,
    input  logic [4:0] dur_i,
    output logic [4:0] elapsed_o,
    output logic [4:0] elapsed_next_o,
    output logic       done_o
);
    logic [4:0] elapsed_q, elapsed_d;

    // Saturate so a long preemption hold cannot wrap the count.
    always_comb begin
        elapsed_d = elapsed_q;
        if (clear_i) begin
            elapsed_d = '0;
        end else if (tick_i && elapsed_q != 5'd31) begin
            elapsed_d = elapsed_q + 5'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            elapsed_q <= '0;
        end else begin
            elapsed_q <= elapsed_d;
        end
    end

    assign elapsed_o      = elapsed_q;
    assign elapsed_next_o = elapsed_d;
    assign done_o         = tick_i && (({1'b0, elapsed_q} + 6'd1) >= {1'b0, dur_i});
endmodule

// File: rtl/crossing_phase_scheduler.sv
// Demand-driven crossing phase scheduler with pedestrian walk grants.
// Emergency preemption is built only when ARB_PREEMPT_EN is defined.
module crossing_phase_scheduler
    import traffic_pkg::*;
#(
    parameter logic [4:0] MIN_GREEN   = DefMinGreen,
    parameter logic [4:0] MAX_GREEN   = DefMaxGreen,
    parameter logic [4:0] YELLOW_TIME = DefYellow,
    parameter logic [4:0] ALLRED_TIME = DefAllred,
    parameter logic [4:0] WALK_TIME   = DefWalk
) (
    input logic                       clk_i,
    input logic                       rst_i,
    crossing_phase_scheduler_if.slave bus
);
    phase_e     phase_q, phase_d;
    logic [1:0] ped_q, ped_d;
    logic       walk_h_q, walk_h_d, walk_v_q, walk_v_d;
    logic       pre_act_q, pre_act_d;
    logic [4:0] remaining_q, remaining_d;
    logic       tmr_clear, tmr_done;
    logic [4:0] tmr_dur, elapsed, elapsed_next;
    logic       preempt_req, opp_h, opp_v, entry_h, entry_v;

`ifdef ARB_PREEMPT_EN
    dir_e last_dir_q, last_dir_d;
    assign preempt_req = (bus.preempt_code != PREEMPT_NONE);
`else
    assign preempt_req = 1'b0;
`endif

    function automatic logic [4:0] shown_dur(phase_e ph);
        case (ph)
            PhGreenH, PhGreenV:   shown_dur = MAX_GREEN;
            PhYellowH, PhYellowV: shown_dur = YELLOW_TIME;
            PhAllredH, PhAllredV: shown_dur = ALLRED_TIME;
            default:              shown_dur = '0;
        endcase
    endfunction

    phase_timer u_timer (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clear_i        (tmr_clear),
        .tick_i         (bus.tick),
        .dur_i          (tmr_dur),
        .elapsed_o      (elapsed),
        .elapsed_next_o (elapsed_next),
        .done_o         (tmr_done)
    );

    always_comb begin
        phase_d = phase_q;
        tmr_dur = 5'd31;
        opp_h   = bus.car_wait_ver | ped_q[1];
        opp_v   = bus.car_wait_hor | ped_q[0];
        case (phase_q)
            PhGreenH, PhGreenV: tmr_dur = MIN_GREEN;
            PhYellowH, PhYellowV: tmr_dur = YELLOW_TIME;
            PhAllredH, PhAllredV: tmr_dur = ALLRED_TIME;
            default: tmr_dur = 5'd31;
        endcase
        case (phase_q)
            PhGreenH:  if (preempt_req || (tmr_done && opp_h)) phase_d = PhYellowH;
            PhYellowH: if (tmr_done) phase_d = PhAllredH;
            PhAllredH: if (tmr_done) phase_d = (pre_act_q || preempt_req) ? PhPreempt : PhGreenV;
            PhGreenV:  if (preempt_req || (tmr_done && opp_v)) phase_d = PhYellowV;
            PhYellowV: if (tmr_done) phase_d = PhAllredV;
            PhAllredV: if (tmr_done) phase_d = (pre_act_q || preempt_req) ? PhPreempt : PhGreenH;
`ifdef ARB_PREEMPT_EN
            PhPreempt: if (!preempt_req) phase_d = (last_dir_q == DirV) ? PhGreenH : PhGreenV;
`endif
            default:   phase_d = PhGreenH;
        endcase

        // A green resting at MAX_GREEN with no opposing demand restarts its count.
        tmr_clear = (phase_d != phase_q) ||
                    (bus.tick && (phase_q == PhGreenH || phase_q == PhGreenV) &&
                     (({1'b0, elapsed} + 6'd1) == {1'b0, MAX_GREEN}));

        pre_act_d = (pre_act_q | preempt_req) & ~((phase_q == PhPreempt) & ~preempt_req);

        entry_h  = (phase_d == PhGreenH) && (phase_q != PhGreenH);
        entry_v  = (phase_d == PhGreenV) && (phase_q != PhGreenV);
        ped_d[0] = (ped_q[0] | bus.ped_req_hor) & ~entry_h;
        ped_d[1] = (ped_q[1] | bus.ped_req_ver) & ~entry_v;
        walk_h_d = (entry_h & (ped_q[0] | bus.ped_req_hor)) |
                   (walk_h_q & (phase_d == PhGreenH) & (elapsed_next < WALK_TIME));
        walk_v_d = (entry_v & (ped_q[1] | bus.ped_req_ver)) |
                   (walk_v_q & (phase_d == PhGreenV) & (elapsed_next < WALK_TIME));
        if (pre_act_d) begin
            walk_h_d = 1'b0;
            walk_v_d = 1'b0;
        end

        remaining_d = shown_dur(phase_d) - elapsed_next;
        if (phase_d == PhPreempt) remaining_d = '0;

`ifdef ARB_PREEMPT_EN
        last_dir_d = last_dir_q;
        if (phase_q == PhGreenH) last_dir_d = DirH;
        if (phase_q == PhGreenV) last_dir_d = DirV;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q     <= PhGreenH;
            ped_q       <= '0;
            walk_h_q    <= 1'b0;
            walk_v_q    <= 1'b0;
            pre_act_q   <= 1'b0;
            remaining_q <= MAX_GREEN;
`ifdef ARB_PREEMPT_EN
            last_dir_q  <= DirV;
`endif
        end else begin
            phase_q     <= phase_d;
            ped_q       <= ped_d;
            walk_h_q    <= walk_h_d;
            walk_v_q    <= walk_v_d;
            pre_act_q   <= pre_act_d;
            remaining_q <= remaining_d;
`ifdef ARB_PREEMPT_EN
            last_dir_q  <= last_dir_d;
`endif
        end
    end

    assign bus.phase          = phase_q;
    assign bus.ped_pending    = ped_q;
    assign bus.walk_hor       = walk_h_q;
    assign bus.walk_ver       = walk_v_q;
    assign bus.remaining      = remaining_q;
    assign bus.preempt_active = pre_act_q;
endmodule

// File: tb/tb_crossing_phase_scheduler.sv
// Directed and randomized bench for crossing_phase_scheduler against a cycle-level model of
// the phase rules; preemption expectations follow ARB_PREEMPT_EN.
module tb_crossing_phase_scheduler;
`ifdef ARB_PREEMPT_EN
    localparam bit PreEn = 1'b1;
`else
    localparam bit PreEn = 1'b0;
`endif
    localparam int MinG = 5, MaxG = 20, YelT = 3, ArT = 1, WalkT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    crossing_phase_scheduler_if bus ();

    crossing_phase_scheduler dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    bit         s_cwh, s_cwv, s_prh, s_prv;
    logic [2:0] s_code = 3'b111;

    // Model state: phase number 0..6, ticks since phase entry, latched requests, walk, preempt.
    int m_ph, m_el, m_ped_h, m_ped_v, m_walk_h, m_walk_v, m_pre, m_last_v;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int model_remaining();
        if (m_ph == 6) return 0;
        if (m_ph % 3 == 0) return MaxG - m_el;
        if (m_ph % 3 == 1) return YelT - m_el;
        return ArT - m_el;
    endfunction

    task automatic model_step(input bit r, input bit t);
        int  nph, nel;
        bit  req, opp, reload, nped_h, nped_v;
        if (r) begin
            m_ph = 0; m_el = 0; m_ped_h = 0; m_ped_v = 0;
            m_walk_h = 0; m_walk_v = 0; m_pre = 0; m_last_v = 1;
            return;
        end
        req    = PreEn && (s_code != 3'b111);
        nph    = m_ph;
        reload = 0;
        if (m_ph == 0 || m_ph == 3) begin
            opp = (m_ph == 0) ? (s_cwv || m_ped_v != 0) : (s_cwh || m_ped_h != 0);
            if (req || (t && m_el + 1 >= MinG && opp)) nph = m_ph + 1;
            else if (t && m_el + 1 == MaxG) reload = 1;
        end else if (m_ph == 1 || m_ph == 4) begin
            if (t && m_el + 1 >= YelT) nph = m_ph + 1;
        end else if (m_ph == 2 || m_ph == 5) begin
            if (t && m_el + 1 >= ArT) nph = (m_pre != 0 || req) ? 6 : (m_ph == 2 ? 3 : 0);
        end else if (!req) begin
            nph = (m_last_v != 0) ? 0 : 3;
        end
        if (nph != m_ph || reload) nel = 0;
        else if (t) nel = (m_el < 31) ? m_el + 1 : 31;
        else nel = m_el;

        nped_h = (m_ped_h != 0) || s_prh;
        nped_v = (m_ped_v != 0) || s_prv;
        if (nph == 0 && m_ph != 0) begin
            m_walk_h = nped_h; m_ped_h = 0;
        end else begin
            m_walk_h = (m_walk_h != 0) && nph == 0 && nel < WalkT; m_ped_h = nped_h;
        end
        if (nph == 3 && m_ph != 3) begin
            m_walk_v = nped_v; m_ped_v = 0;
        end else begin
            m_walk_v = (m_walk_v != 0) && nph == 3 && nel < WalkT; m_ped_v = nped_v;
        end
        if (m_ph == 0) m_last_v = 0;
        if (m_ph == 3) m_last_v = 1;
        m_pre = ((m_pre != 0) || req) && !(m_ph == 6 && !req);
        if (m_pre != 0) begin
            m_walk_h = 0; m_walk_v = 0;
        end
        m_ph = nph;
        m_el = nel;
    endtask

    task automatic step(input bit r, input bit t);
        rst              = r;
        bus.tick         = t;
        bus.car_wait_hor = s_cwh;
        bus.car_wait_ver = s_cwv;
        bus.ped_req_hor  = s_prh;
        bus.ped_req_ver  = s_prv;
        bus.preempt_code = s_code;
        @(posedge clk);
        model_step(r, t);
        #1;
        check("phase", int'(bus.phase), m_ph);
        check("remaining", int'(bus.remaining), model_remaining());
        check("ped_pending", int'(bus.ped_pending), m_ped_v * 2 + m_ped_h);
        check("walk_hor", int'(bus.walk_hor), m_walk_h);
        check("walk_ver", int'(bus.walk_ver), m_walk_v);
        check("preempt_active", int'(bus.preempt_active), m_pre);
        s_prh = 0;
        s_prv = 0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1);
            step(1'b0, 1'b0);
        end
    endtask

    initial begin
        bus.tick = 0; bus.car_wait_hor = 0; bus.car_wait_ver = 0;
        bus.ped_req_hor = 0; bus.ped_req_ver = 0; bus.preempt_code = 3'b111;
        if (!PreEn) s_code = 3'b000;

        // Rest in green with no demand.
        step(1'b1, 1'b0);
        check("rst_phase", int'(bus.phase), 0);
        check("rst_remaining", int'(bus.remaining), 20);
        check("rst_ped", int'(bus.ped_pending), 0);
        check("rst_preempt", int'(bus.preempt_active), 0);
        tick_n(5);
        check("rem_after5", int'(bus.remaining), 15);
        tick_n(15);
        check("rem_reload", int'(bus.remaining), 20);
        tick_n(5);
        check("rest_green", int'(bus.phase), 0);

        // Vehicle demand on vertical.
        step(1'b1, 1'b0);
        s_cwv = 1;
        tick_n(5);
        check("yellow_h_t5", int'(bus.phase), 1);
        tick_n(3);
        check("allred_h_t8", int'(bus.phase), 2);
        tick_n(1);
        check("green_v_t9", int'(bus.phase), 3);
        s_cwv = 0;

        // Pedestrian request on vertical.
        step(1'b1, 1'b0);
        tick_n(2);
        s_prv = 1;
        step(1'b0, 1'b0);
        check("ped_latched", int'(bus.ped_pending), 2);
        tick_n(7);
        check("ped_green_v", int'(bus.phase), 3);
        check("ped_cleared", int'(bus.ped_pending), 0);
        check("walk_v_on", int'(bus.walk_ver), 1);
        tick_n(3);
        check("walk_v_t12", int'(bus.walk_ver), 1);
        tick_n(1);
        check("walk_v_t13", int'(bus.walk_ver), 0);

`ifdef ARB_PREEMPT_EN
        step(1'b1, 1'b0);
        s_cwv = 1;
        tick_n(9);
        s_cwv = 0;
        tick_n(2);
        s_code = 3'b110;
        step(1'b0, 1'b0);
        check("pre_yellow_v", int'(bus.phase), 4);
        check("pre_active", int'(bus.preempt_active), 1);
        tick_n(3);
        check("pre_allred_v", int'(bus.phase), 5);
        tick_n(1);
        check("pre_hold", int'(bus.phase), 6);
        tick_n(2);
        check("pre_still", int'(bus.phase), 6);
        s_code = 3'b111;
        step(1'b0, 1'b0);
        check("pre_release", int'(bus.phase), 0);
        check("pre_cleared", int'(bus.preempt_active), 0);
`endif

        // Reset during YELLOW_V with a coincident tick.
        step(1'b1, 1'b0);
        s_cwv = 1;
        tick_n(9);
        s_cwv = 0;
        s_cwh = 1;
        tick_n(5);
        check("in_yellow_v", int'(bus.phase), 4);
        s_prv = 1;
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        check("rst_tick_phase", int'(bus.phase), 0);
        check("rst_tick_rem", int'(bus.remaining), 20);
        check("rst_tick_ped", int'(bus.ped_pending), 0);
        s_cwh = 0;
        step(1'b0, 1'b0);

        // Randomized demand, tick spacing, preemption and occasional reset.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 15) == 0) s_cwh = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) s_cwv = 1'($urandom_range(0, 1));
            s_prh = ($urandom_range(0, 19) == 0);
            s_prv = ($urandom_range(0, 19) == 0);
            if (PreEn) begin
                if ($urandom_range(0, 79) == 0) s_code = 3'($urandom_range(0, 6));
                else if ($urandom_range(0, 19) == 0) s_code = 3'b111;
            end else begin
                s_code = 3'($urandom_range(0, 7));
            end
            step($urandom_range(0, 599) == 0, $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/crossing_phase_scheduler.md
# crossing_phase_scheduler

- Sequences the intersection's signal phases: horizontal green/yellow/all-red, then vertical green/yellow/all-red.
- Arbitrates the single green between horizontal and vertical demand: vehicle-wait inputs and latched pedestrian requests.
- Grants pedestrian walk windows and supports emergency preemption from the 3-bit keyboard code.
- Sits between the 1 Hz tick generator and the light/crosswalk datapaths and HEX countdown display, replacing open-loop phase stepping with demand-driven scheduling.

## Interface
- MIN_GREEN, 5: ticks a green holds before it may yield.
- MAX_GREEN, 20: ticks after which a green must yield if opposing demand exists.
- YELLOW_TIME, 3: ticks per yellow phase.
- ALLRED_TIME, 1: ticks per all-red clearance phase.
- WALK_TIME, 4: ticks of walk at the start of a green; must be ≤ MIN_GREEN.
- All durations are 5-bit values, range 1..31.

Ports:
- Clock  in  1  system clock (CLOCK_50 domain). One clock; reset is synchronous and active-high.
- Reset  in  1  synchronous, active-high.
- Tick  in  1  one-cycle enable pulse, 1 Hz.
- car_wait_hor, car_wait_ver  in  1 each  vehicle demand level.
- ped_req_hor, ped_req_ver  in  1 each  pedestrian button, sampled every cycle.
- preempt_code  in  3  3'b111 = none; any other value = preempt request.
- phase  out  3  current phase encoding.
- walk_hor, walk_ver  out  1 each  walk window active.
- ped_pending  out  2  {ver, hor} latched requests.
- remaining  out  5  ticks left in current phase.
- preempt_active  out  1  preemption in progress.

## Operation
- Phases and encodings:
  - GREEN_H = 0, YELLOW_H = 1, ALLRED_H = 2
  - GREEN_V = 3, YELLOW_V = 4, ALLRED_V = 5
  - PREEMPT = 6 (all-red hold)
- elapsed counter:
  - Cleared on every phase entry.
  - Increments on each Tick.
  - remaining = duration − elapsed, where duration is MAX_GREEN for greens, YELLOW_TIME for yellows, ALLRED_TIME for all-reds, and 0 in PREEMPT.
- Green exit, evaluated on Tick:
  - Yield to own yellow if elapsed+1 ≥ MIN_GREEN and opposing demand exists (opposing car_wait or opposing ped_pending bit).
  - Otherwise, at elapsed+1 = MAX_GREEN with no opposing demand: elapsed reloads to 0 and the phase stays green (rest in green).
- Yellow → own all-red → opposite green, each exiting on the Tick that completes its duration.
- Pedestrian requests:
  - ped_req sets its ped_pending bit.
  - The bit clears on the cycle of entry to that direction's green, and walk is granted for the first WALK_TIME ticks of that green.
  - A request arriving in the same cycle as that entry is treated as served.
  - A request arriving during its own green, after entry, stays pending for the next cycle of that direction.
- Preemption (any preempt_code ≠ 3'b111):
  - During a green: go to that direction's yellow next cycle, without waiting for a Tick; elapsed cleared.
  - During a yellow or all-red: complete the normal yellow/all-red sequence, then enter PREEMPT instead of the next green.
  - PREEMPT holds while the code is ≠ 3'b111.
  - On release, the next cycle enters the green opposite the last direction that held green. A last_dir register tracks this.
  - preempt_active = 1 from the cycle after the code is detected until PREEMPT is exited.
  - Walk outputs are forced to 0 while preempt_active = 1.
- Reset values:
  - phase = GREEN_H, elapsed = 0, remaining = MAX_GREEN.
  - ped_pending = 0, walk_* = 0, preempt_active = 0, last_dir = V.

## Timing
- All outputs are registered.
- Phase changes the cycle after the qualifying Tick.
- Preempt detection latency is 1 cycle from preempt_code.
- Reset wins over a coincident Tick, ped_req or preempt.
- A Tick coincident with a phase entry is not counted in the new phase.

## Configuration
- ARB_PREEMPT_EN defined: preemption behaves as specified above.
- Not defined:
  - preempt_code is ignored.
  - preempt_active is tied to 0.
  - PREEMPT is unreachable; last_dir is not needed.

## Structure
- Package traffic_pkg holds:
  - The phase encoding constants.
  - PREEMPT_NONE = 3'b111.
  - The default duration constants.
- One sub-module, phase_timer: elapsed counter with clear/Tick inputs and a done compare against a loaded duration.

## Test plan
- Reset, all demand 0, 25 Ticks:
  - phase stays GREEN_H.
  - remaining = 20 at reset, 15 after 5 Ticks, reloads to 20 after the 20th Tick.
- car_wait_ver = 1 from reset:
  - YELLOW_H after Tick 5, ALLRED_H after Tick 8, GREEN_V after Tick 9.
- ped_req_ver pulse at Tick 2, no cars:
  - ped_pending = 2'b10 the next cycle.
  - GREEN_V after Tick 9 with ped_pending cleared; walk_ver = 1 until Tick 13.
- preempt_code = 3'b110 during GREEN_V at elapsed 2:
  - Next cycle: YELLOW_V, preempt_active = 1.
  - ALLRED_V after 3 Ticks, then PREEMPT.
  - Code back to 3'b111: GREEN_H the next cycle, preempt_active = 0.
- Reset asserted in YELLOW_V coincident with a Tick:
  - Next cycle: phase = GREEN_H, remaining = 20, ped_pending = 0.
- Build without ARB_PREEMPT_EN, preempt_code = 3'b000:
  - Normal sequencing is unchanged and preempt_active stays 0.
